datapath: RTL and testbench

K&S processor datapath: program counter, instruction register, 4×16-bit register file, ALU and flags register, plus the opcode decoder that feeds `decoded_instruction` back to the control unit. It is the responder side of the control-unit interface. It executes the strobes it receives (`pc_enable`, `ir_enable`, `write_reg_enable`, `flags_reg_enable`, `branch`, selects, `operation`) and returns decoded opcode and registered flags. It sits between the control unit and the single-port 32×16 RAM.

---
 rtl/k_and_s_pkg.sv | 93 +++++++++
 rtl/ks_regfile.sv | 46 ++++
 rtl/datapath.sv | 197 +++++++++++++++++++
 tb/tb_datapath.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k_and_s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : k_and_s_pkg
// Purpose  : Shared types and constants for the K&S processor: decoded
//            instruction enum, opcode values, instruction field positions
//            and the ALU operation encoding used on the `operation` strobe.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package k_and_s_pkg;

  // Decoded opcode as seen by the control unit.
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_HALT   = 4'd13
  } decoded_instruction_type;

  // Fixed datapath geometry.
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 5;
  localparam int NUM_REGS  = 4;
  localparam int REG_IDX_W = 2;

  // Opcode values (IR[15:8]).
  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h91;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNZERO = 8'h03;
  localparam logic [7:0] OP_BNEG   = 8'h04;
  localparam logic [7:0] OP_BNNEG  = 8'h05;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  // Field LSB positions inside the instruction register.
  localparam int OPCODE_LSB   = 8;   // opcode      IR[15:8]
  localparam int LS_REG_LSB   = 5;   // load/store  IR[6:5]
  localparam int ALU_DST_LSB  = 4;   // ALU dst     IR[5:4]
  localparam int ALU_A_LSB    = 2;   // ALU A       IR[3:2]
  localparam int ALU_B_LSB    = 0;   // ALU B       IR[1:0]
  localparam int MOVE_DST_LSB = 2;   // MOVE dst    IR[3:2]
  localparam int MOVE_SRC_LSB = 0;   // MOVE src    IR[1:0]
  localparam int ADDR_LSB     = 0;   // address     IR[4:0]

  // ALU operation, same codes as the `operation` input.
  typedef enum logic [1:0] {
    ALU_OR  = 2'b00,
    ALU_ADD = 2'b01,
    ALU_SUB = 2'b10,
    ALU_AND = 2'b11
  } alu_op_t;

  // Opcode byte to decoded instruction; unknown codes behave as NOP.
  function automatic decoded_instruction_type decode_opcode(input logic [7:0] op);
    decoded_instruction_type d;
    case (op)
      OP_LOAD:   d = I_LOAD;
      OP_STORE:  d = I_STORE;
      OP_MOVE:   d = I_MOVE;
      OP_ADD:    d = I_ADD;
      OP_SUB:    d = I_SUB;
      OP_AND:    d = I_AND;
      OP_OR:     d = I_OR;
      OP_BRANCH: d = I_BRANCH;
      OP_BZERO:  d = I_BZERO;
      OP_BNZERO: d = I_BNZERO;
      OP_BNEG:   d = I_BNEG;
      OP_BNNEG:  d = I_BNNEG;
      OP_HALT:   d = I_HALT;
      default:   d = I_NOP;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ks_regfile.sv
`default_nettype none
// ============================================================================
// Module   : ks_regfile
// Purpose  : 4 x 16-bit register file with one synchronous write port and
//            three combinational read ports (ALU A, ALU B, store data).
// Ports    : clk, rst_n (sync, active-low)
//            we, waddr[1:0], wdata[15:0]        - write port
//            raddr_a/raddr_b/raddr_s[1:0]       - read addresses
//            rdata_a/rdata_b/rdata_s[15:0]      - read data
// Revision : 1.0 - initial release
// ============================================================================
module ks_regfile
  import k_and_s_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [REG_IDX_W-1:0] raddr_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  input  logic [REG_IDX_W-1:0] raddr_s,
  output logic [DATA_W-1:0]    rdata_a,
  output logic [DATA_W-1:0]    rdata_b,
  output logic [DATA_W-1:0]    rdata_s
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we) begin
      r_regs[waddr] <= wdata;
    end
  end

  // Reads see pre-edge contents, so write-back to a source register is safe.
  assign rdata_a = r_regs[raddr_a];
  assign rdata_b = r_regs[raddr_b];
  assign rdata_s = r_regs[raddr_s];

endmodule
`default_nettype wire

// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
// Module   : datapath
// Purpose  : K&S processor datapath: PC, IR, register file, ALU, flags
//            register and opcode decoder. Executes control-unit strobes and
//            returns the decoded opcode and registered flags.
// Ports    : clk, rst_n (sync, active-low)
//            branch, pc_enable, ir_enable, write_reg_enable,
//            flags_reg_enable, addr_sel, c_sel, operation[1:0] - control
//            data_in[15:0]   - RAM read data
//            ram_addr[4:0]   - RAM address (PC or IR[4:0])
//            data_out[15:0]  - RAM write data (R[IR[6:5]])
//            decoded_instruction - decoded opcode
//            zero_op, neg_op, unsigned_overflow, signed_overflow - flags
// Config   : KS_HALT_LOCK_EN - when defined, a decoded HALT blocks PC, IR
//            and register writes until reset.
// Revision : 1.0 - initial release
// ============================================================================
module datapath
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic [1:0]              operation,
  input  logic [DATA_W-1:0]       data_in,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow
);

  logic [ADDR_W-1:0]    r_pc;
  logic [DATA_W-1:0]    r_ir;
  logic                 r_zero;
  logic                 r_neg;
  logic                 r_uov;
  logic                 r_sov;

  logic                 w_halted;
  logic                 w_is_move;
  logic                 w_is_load;
  logic [REG_IDX_W-1:0] w_dst_idx;
  logic [REG_IDX_W-1:0] w_a_idx;
  logic [REG_IDX_W-1:0] w_b_idx;
  logic [REG_IDX_W-1:0] w_s_idx;
  logic [DATA_W-1:0]    w_rd_a;
  logic [DATA_W-1:0]    w_rd_b;
  logic [DATA_W-1:0]    w_rd_s;
  logic [DATA_W-1:0]    w_alu_a;
  logic [DATA_W-1:0]    w_alu_b;
  logic [DATA_W-1:0]    w_wdata;
  alu_op_t              w_alu_op;
  logic [DATA_W:0]      w_sum;
  logic [DATA_W:0]      w_diff;
  logic [DATA_W-1:0]    w_alu_result;
  logic                 w_alu_uov;
  logic                 w_alu_sov;
  logic                 w_unused_ir7;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  assign decoded_instruction = decode_opcode(r_ir[OPCODE_LSB +: 8]);
  assign w_is_move           = (decoded_instruction == I_MOVE);
  assign w_is_load           = (decoded_instruction == I_LOAD);

  // IR[7] is not part of any instruction field.
  assign w_unused_ir7 = r_ir[7];

`ifdef KS_HALT_LOCK_EN
  // IR is frozen while halted, so the decode itself holds the lock.
  assign w_halted = (decoded_instruction == I_HALT);
`else
  assign w_halted = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Register selection
  // --------------------------------------------------------------------------
  always_comb begin
    w_dst_idx = r_ir[ALU_DST_LSB +: REG_IDX_W];
    if (w_is_load) begin
      w_dst_idx = r_ir[LS_REG_LSB +: REG_IDX_W];
    end else if (w_is_move) begin
      w_dst_idx = r_ir[MOVE_DST_LSB +: REG_IDX_W];
    end
  end

  assign w_a_idx = w_is_move ? r_ir[MOVE_SRC_LSB +: REG_IDX_W]
                             : r_ir[ALU_A_LSB +: REG_IDX_W];
  assign w_b_idx = r_ir[ALU_B_LSB +: REG_IDX_W];
  assign w_s_idx = r_ir[LS_REG_LSB +: REG_IDX_W];

  ks_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (write_reg_enable && !w_halted),
    .waddr   (w_dst_idx),
    .wdata   (w_wdata),
    .raddr_a (w_a_idx),
    .raddr_b (w_b_idx),
    .raddr_s (w_s_idx),
    .rdata_a (w_rd_a),
    .rdata_b (w_rd_b),
    .rdata_s (w_rd_s)
  );

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  // MOVE forces B to zero so that an OR passes the source through.
  assign w_alu_a  = w_rd_a;
  assign w_alu_b  = w_is_move ? '0 : w_rd_b;
  assign w_alu_op = alu_op_t'(operation);

  // 17-bit add/sub: bit 16 is the carry (add) or borrow (sub).
  assign w_sum  = {1'b0, w_alu_a} + {1'b0, w_alu_b};
  assign w_diff = {1'b0, w_alu_a} - {1'b0, w_alu_b};

  always_comb begin
    w_alu_result = '0;
    w_alu_uov    = 1'b0;
    w_alu_sov    = 1'b0;
    case (w_alu_op)
      ALU_ADD: begin
        w_alu_result = w_sum[DATA_W-1:0];
        w_alu_uov    = w_sum[DATA_W];
        w_alu_sov    = (w_alu_a[DATA_W-1] == w_alu_b[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != w_alu_a[DATA_W-1]);
      end
      ALU_SUB: begin
        w_alu_result = w_diff[DATA_W-1:0];
        w_alu_uov    = w_diff[DATA_W];
        w_alu_sov    = (w_alu_a[DATA_W-1] != w_alu_b[DATA_W-1]) &&
                       (w_diff[DATA_W-1] != w_alu_a[DATA_W-1]);
      end
      ALU_AND: w_alu_result = w_alu_a & w_alu_b;
      default: w_alu_result = w_alu_a | w_alu_b;
    endcase
  end

  assign w_wdata = c_sel ? data_in : w_alu_result;

  // --------------------------------------------------------------------------
  // PC, IR and flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= '0;
      r_ir <= '0;
    end else if (!w_halted) begin
      if (pc_enable) begin
        // Natural 5-bit overflow wraps 31 back to 0.
        r_pc <= branch ? r_ir[ADDR_LSB +: ADDR_W] : r_pc + 5'd1;
      end
      if (ir_enable) begin
        r_ir <= data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_uov  <= 1'b0;
      r_sov  <= 1'b0;
    end else if (flags_reg_enable) begin
      r_zero <= (w_alu_result == '0);
      r_neg  <= w_alu_result[DATA_W-1];
      r_uov  <= w_alu_uov;
      r_sov  <= w_alu_sov;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ram_addr          = addr_sel ? r_pc : r_ir[ADDR_LSB +: ADDR_W];
  assign data_out          = w_rd_s;
  assign zero_op           = r_zero;
  assign neg_op            = r_neg;
  assign unsigned_overflow = r_uov;
  assign signed_overflow   = r_sov;

endmodule
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_datapath
// Purpose  : Self-checking bench for datapath. Stimulus drives strobes and
//            pushes the expected post-edge outputs into a queue; a monitor
//            pops and compares at each falling edge.
// Config   : KS_HALT_LOCK_EN - selects the halt-lock behaviour in the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datapath;
  import k_and_s_pkg::*;

`ifdef KS_HALT_LOCK_EN
  localparam bit HALT_LOCK = 1'b1;
`else
  localparam bit HALT_LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic branch = 1'b0, pc_enable = 1'b0, ir_enable = 1'b0;
  logic write_reg_enable = 1'b0, flags_reg_enable = 1'b0;
  logic addr_sel = 1'b0, c_sel = 1'b0;
  logic [1:0]  operation = 2'b00;
  logic [15:0] data_in = 16'h0000;
  logic [4:0]  ram_addr;
  logic [15:0] data_out;
  decoded_instruction_type decoded_instruction;
  logic zero_op, neg_op, unsigned_overflow, signed_overflow;

  always #5 clk = ~clk;

  datapath dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .write_reg_enable    (write_reg_enable),
    .flags_reg_enable    (flags_reg_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .data_in             (data_in),
    .ram_addr            (ram_addr),
    .data_out            (data_out),
    .decoded_instruction (decoded_instruction),
    .zero_op             (zero_op),
    .neg_op              (neg_op),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow)
  );

  typedef struct packed {
    logic [4:0]  ra;
    logic [15:0] dout;
    logic [3:0]  dec;
    logic        z, n, uo, so;
  } obs_t;

  obs_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int          m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_r [4];
  logic        m_z, m_n, m_uo, m_so;

  function automatic decoded_instruction_type ref_decode(input logic [7:0] op);
    case (op)
      8'h81: return I_LOAD;
      8'h82: return I_STORE;
      8'h91: return I_MOVE;
      8'hA1: return I_ADD;
      8'hA2: return I_SUB;
      8'hA3: return I_AND;
      8'hA4: return I_OR;
      8'h01: return I_BRANCH;
      8'h02: return I_BZERO;
      8'h03: return I_BNZERO;
      8'h04: return I_BNEG;
      8'h05: return I_BNNEG;
      8'hFF: return I_HALT;
      default: return I_NOP;
    endcase
  endfunction

  function automatic int sx(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // One rising edge of the datapath, computed from the architectural rules.
  task automatic model_edge();
    int a, b, res, sres, dst;
    bit uo, so, lock;
    decoded_instruction_type d;
    logic [15:0] wval;
    if (!rst_n) begin
      m_pc = 0; m_ir = 16'h0000;
      for (int i = 0; i < 4; i++) m_r[i] = 16'h0000;
      m_z = 0; m_n = 0; m_uo = 0; m_so = 0;
      return;
    end
    d    = ref_decode(m_ir[15:8]);
    lock = HALT_LOCK && (d == I_HALT);
    a    = (d == I_MOVE) ? int'(m_r[m_ir[1:0]]) : int'(m_r[m_ir[3:2]]);
    b    = (d == I_MOVE) ? 0 : int'(m_r[m_ir[1:0]]);
    uo = 0; so = 0;
    case (operation)
      2'b00: res = a | b;
      2'b01: begin
        res  = a + b;
        uo   = (res > 65535);
        res  = res % 65536;
        sres = sx(a) + sx(b);
        so   = (sres > 32767) || (sres < -32768);
      end
      2'b10: begin
        uo   = (a < b);
        res  = (a - b + 65536) % 65536;
        sres = sx(a) - sx(b);
        so   = (sres > 32767) || (sres < -32768);
      end
      default: res = a & b;
    endcase
    if (d == I_LOAD)      dst = int'(m_ir[6:5]);
    else if (d == I_MOVE) dst = int'(m_ir[3:2]);
    else                  dst = int'(m_ir[5:4]);
    wval = c_sel ? data_in : 16'(res);
    if (write_reg_enable && !lock) m_r[dst] = wval;
    if (flags_reg_enable) begin
      m_z = (res == 0); m_n = (res >= 32768); m_uo = uo; m_so = so;
    end
    if (pc_enable && !lock) m_pc = branch ? int'(m_ir[4:0]) : (m_pc + 1) % 32;
    if (ir_enable && !lock) m_ir = data_in;
  endtask

  // Apply one cycle of stimulus; returns just after the following falling edge.
  task automatic step(input bit rn, input bit br, input bit pce, input bit ire,
                      input bit wre, input bit fe, input bit as, input bit cs,
                      input logic [1:0] op, input logic [15:0] din);
    obs_t e;
    #1;
    rst_n = rn; branch = br; pc_enable = pce; ir_enable = ire;
    write_reg_enable = wre; flags_reg_enable = fe; addr_sel = as; c_sel = cs;
    operation = op; data_in = din;
    @(posedge clk);
    model_edge();
    e.ra   = addr_sel ? 5'(m_pc) : m_ir[4:0];
    e.dout = m_r[m_ir[6:5]];
    e.dec  = ref_decode(m_ir[15:8]);
    e.z = m_z; e.n = m_n; e.uo = m_uo; e.so = m_so;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input bit as);
    step(1, 0, 0, 0, 0, 0, as, 0, 2'b00, 16'h0000);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs with the oldest expectation each falling edge.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.ra = ram_addr; a.dout = data_out; a.dec = decoded_instruction;
        a.z = zero_op; a.n = neg_op; a.uo = unsigned_overflow; a.so = signed_overflow;
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL scoreboard @%0t: got ra=%0h dout=%0h dec=%0d zn/uo/so=%b%b%b%b expected ra=%0h dout=%0h dec=%0d zn/uo/so=%b%b%b%b",
                   $time, a.ra, a.dout, a.dec, a.z, a.n, a.uo, a.so,
                   e.ra, e.dout, e.dec, e.z, e.n, e.uo, e.so);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [7:0] ops [14] = '{8'h00, 8'h81, 8'h82, 8'h91, 8'hA1, 8'hA2, 8'hA3,
                           8'hA4, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF};

  initial begin
    logic [15:0] din;
    @(negedge clk);
    // Reset for two cycles
    step(0, 0, 1, 1, 1, 1, 1, 0, 2'b01, 16'hFFFF);
    step(0, 0, 1, 1, 1, 1, 1, 0, 2'b01, 16'hFFFF);
    check("reset_ram_addr", 32'(ram_addr), 32'h0);
    check("reset_flags", {28'h0, zero_op, neg_op, unsigned_overflow, signed_overflow}, 32'h0);
    check("reset_decode", 32'(decoded_instruction), 32'(I_NOP));
    check("reset_data_out", 32'(data_out), 32'h0);

    // Fetch LOAD R1,[3]
    step(1, 0, 1, 1, 0, 0, 1, 0, 2'b00, 16'h8123);
    check("load_decode", 32'(decoded_instruction), 32'(I_LOAD));
    check("pc_after_fetch", 32'(ram_addr), 32'd1);
    idle(0);
    check("load_ram_addr", 32'(ram_addr), 32'd3);
    step(1, 0, 0, 0, 1, 0, 0, 1, 2'b00, 16'h00AA);
    check("load_r1", 32'(data_out), 32'h00AA);

    // ADD R1 <- R1 + R2 with R1=7FFF, R2=0001
    step(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 16'h8120);
    step(1, 0, 0, 0, 1, 0, 0, 1, 2'b00, 16'h7FFF);
    step(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 16'h8140);
    step(1, 0, 0, 0, 1, 0, 0, 1, 2'b00, 16'h0001);
    step(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 16'hA116);
    step(1, 0, 0, 0, 1, 1, 0, 0, 2'b01, 16'h0000);
    check("add_flags_z_n_uo_so", {28'h0, zero_op, neg_op, unsigned_overflow, signed_overflow}, 32'b0101);
    step(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 16'h8120);
    check("add_result_r1", 32'(data_out), 32'h8000);

    // SUB R0 <- R0 - R3 with R0=3, R3=5
    step(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 16'h8100);
    step(1, 0, 0, 0, 1, 0, 0, 1, 2'b00, 16'h0003);
    step(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 16'h8160);
    step(1, 0, 0, 0, 1, 0, 0, 1, 2'b00, 16'h0005);
    step(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 16'hA203);
    step(1, 0, 0, 0, 1, 1, 0, 0, 2'b10, 16'h0000);
    check("sub_flags_z_n_uo_so", {28'h0, zero_op, neg_op, unsigned_overflow, signed_overflow}, 32'b0110);
    step(1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 16'h8100);
    check("sub_result_r0", 32'(data_out), 32'hFFFE);

    // PC wrap and branch
    step(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 16'h0000);
    for (int i = 0; i < 31; i++) step(1, 0, 1, 0, 0, 0, 1, 0, 2'b00, 16'h0000);
    check("pc_31", 32'(ram_addr), 32'd31);
    step(1, 0, 1, 0, 0, 0, 1, 0, 2'b00, 16'h0000);
    check("pc_wrap", 32'(ram_addr), 32'd0);
    step(1, 0, 0, 1, 0, 0, 1, 0, 2'b00, 16'h0214);
    check("bzero_decode", 32'(decoded_instruction), 32'(I_BZERO));
    step(1, 1, 1, 0, 0, 0, 1, 0, 2'b00, 16'h0000);
    check("branch_taken", 32'(ram_addr), 32'd20);
    step(1, 1, 0, 0, 0, 0, 1, 0, 2'b00, 16'h0000);
    check("branch_no_pc_enable", 32'(ram_addr), 32'd20);

    // HALT: locked or decode-only depending on configuration
    step(1, 0, 0, 1, 0, 0, 1, 0, 2'b00, 16'hFF00);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1, 0, 1, 1, 2'b00, 16'h8123);
`ifdef KS_HALT_LOCK_EN
    check("halt_pc_frozen", 32'(ram_addr), 32'd20);
    check("halt_ir_frozen", 32'(decoded_instruction), 32'(I_HALT));
    step(0, 0, 1, 1, 0, 0, 1, 0, 2'b00, 16'h0000);
    check("halt_unlock_pc", 32'(ram_addr), 32'd0);
    check("halt_unlock_decode", 32'(decoded_instruction), 32'(I_NOP));
`endif

    // Randomized phase
    for (int n = 0; n < 500; n++) begin
      din = 16'($urandom);
      if ($urandom_range(1, 0) == 1) din[15:8] = ops[$urandom_range(13, 0)];
      step(($urandom_range(49, 0) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), din);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
